// File: rtl/mem_stage_wb.sv
// MEM pipeline stage with MEM/WB register. Data memory accesses take MEM_LAT extra
// cycles, during which upstream is stalled and WB receives bubbles.
module mem_stage_wb #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned DEPTH   = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  WB_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ALUOut_i,
    input  logic [31:0] mux7_i,
    input  logic [4:0]  mux3_i,
    output logic [1:0]  WB_o,
    output logic [31:0] MemData_o,
    output logic [31:0] ALUOut_o,
    output logic [4:0]  RDaddr_o,
    output logic        stall_o,
    output logic [31:0] stall_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;

    // Request captured on the IDLE->BUSY edge; inputs are ignored afterwards.
    logic [AW-1:0]   cap_idx_q, cap_idx_d;
    logic [31:0]     cap_data_q, cap_data_d;
    logic [31:0]     cap_alu_q, cap_alu_d;
    logic [4:0]      cap_rd_q, cap_rd_d;
    logic [1:0]      cap_wb_q, cap_wb_d;
    logic            cap_ld_q, cap_ld_d;
    logic            cap_st_q, cap_st_d;

    // MEM/WB register.
    logic [1:0]      wb_q, wb_d;
    logic [31:0]     mem_data_q, mem_data_d;
    logic [31:0]     alu_q, alu_d;
    logic [4:0]      rdaddr_q, rdaddr_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    logic [31:0]     mem_q [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_widx;
    logic [31:0]     mem_wdata;

    logic            req;
    logic [AW-1:0]   in_idx;

    assign req    = MemRead_i | MemWrite_i;
    // Word index; low two bits and bits above the array size are dropped.
    assign in_idx = ALUOut_i[AW+1:2];

    // Next-state, MEM/WB load, memory write enable and stall generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_idx_d   = cap_idx_q;
        cap_data_d  = cap_data_q;
        cap_alu_d   = cap_alu_q;
        cap_rd_d    = cap_rd_q;
        cap_wb_d    = cap_wb_q;
        cap_ld_d    = cap_ld_q;
        cap_st_d    = cap_st_q;
        wb_d        = wb_q;
        mem_data_d  = mem_data_q;
        alu_d       = alu_q;
        rdaddr_d    = rdaddr_q;
        mem_we      = 1'b0;
        mem_widx    = in_idx;
        mem_wdata   = mux7_i;
        stall_o     = 1'b0;

        case (state_q)
            StIdle: begin
                if (!req) begin
                    wb_d       = WB_i;
                    alu_d      = ALUOut_i;
                    rdaddr_d   = mux3_i;
                    mem_data_d = '0;
                end else if (MEM_LAT == 0) begin
                    mem_we     = MemWrite_i;
                    wb_d       = WB_i;
                    alu_d      = ALUOut_i;
                    rdaddr_d   = mux3_i;
                    // A simultaneous read+write is a store; no load data returned.
                    mem_data_d = (MemRead_i && !MemWrite_i) ? mem_q[in_idx] : '0;
                end else begin
                    stall_o    = 1'b1;
                    state_d    = StBusy;
                    cnt_d      = MEM_LAT - 32'd1;
                    wb_d       = 2'b00;
                    cap_idx_d  = in_idx;
                    cap_data_d = mux7_i;
                    cap_alu_d  = ALUOut_i;
                    cap_rd_d   = mux3_i;
                    cap_wb_d   = WB_i;
                    cap_ld_d   = MemRead_i & ~MemWrite_i;
                    cap_st_d   = MemWrite_i;
                end
            end
            StBusy: begin
                stall_o = (cnt_q != 32'd0);
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                    wb_d  = 2'b00;
                end else begin
                    mem_we     = cap_st_q;
                    mem_widx   = cap_idx_q;
                    mem_wdata  = cap_data_q;
                    wb_d       = cap_wb_q;
                    alu_d      = cap_alu_q;
                    rdaddr_d   = cap_rd_q;
                    mem_data_d = cap_ld_q ? mem_q[cap_idx_q] : '0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // FSM, captured request and MEM/WB register state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cap_idx_q   <= '0;
            cap_data_q  <= '0;
            cap_alu_q   <= '0;
            cap_rd_q    <= '0;
            cap_wb_q    <= '0;
            cap_ld_q    <= 1'b0;
            cap_st_q    <= 1'b0;
            wb_q        <= '0;
            mem_data_q  <= '0;
            alu_q       <= '0;
            rdaddr_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_idx_q   <= cap_idx_d;
            cap_data_q  <= cap_data_d;
            cap_alu_q   <= cap_alu_d;
            cap_rd_q    <= cap_rd_d;
            cap_wb_q    <= cap_wb_d;
            cap_ld_q    <= cap_ld_d;
            cap_st_q    <= cap_st_d;
            wb_q        <= wb_d;
            mem_data_q  <= mem_data_d;
            alu_q       <= alu_d;
            rdaddr_q    <= rdaddr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Data memory write port; not reset, and no write while reset is held.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    assign WB_o        = wb_q;
    assign MemData_o   = mem_data_q;
    assign ALUOut_o    = alu_q;
    assign RDaddr_o    = rdaddr_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_mem_stage_wb.sv
// Directed bench for mem_stage_wb with a scoreboard of expected MEM/WB entries.
module tb_mem_stage_wb;

    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned DEPTH   = 256;

    logic        clk;
    logic        rst;
    logic [1:0]  wb_i;
    logic        rd_i;
    logic        wr_i;
    logic [31:0] alu_i;
    logic [31:0] data_i;
    logic [4:0]  dst_i;
    logic [1:0]  wb_o;
    logic [31:0] md_o;
    logic [31:0] alu_o;
    logic [4:0]  dst_o;
    logic        stall;
    logic [31:0] stall_cnt;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [31:0] md;
        logic [4:0]  rd;
    } wb_t;

    wb_t         sb[$];
    logic [31:0] model [int];
    int          checks;
    int          errors;
    int          exp_stalls;

    mem_stage_wb #(
        .MEM_LAT(MEM_LAT),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .WB_i       (wb_i),
        .MemRead_i  (rd_i),
        .MemWrite_i (wr_i),
        .ALUOut_i   (alu_i),
        .mux7_i     (data_i),
        .mux3_i     (dst_i),
        .WB_o       (wb_o),
        .MemData_o  (md_o),
        .ALUOut_o   (alu_o),
        .RDaddr_o   (dst_o),
        .stall_o    (stall),
        .stall_cnt_o(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [70:0] got, input logic [70:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Every valid WB entry must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && wb_o !== 2'b00) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL wb_unexpected observed=%0h expected=none", {wb_o, alu_o, md_o, dst_o});
            end
            if (sb.size() != 0) begin
                chk("wb_entry", {wb_o, alu_o, md_o, dst_o}, sb.pop_front());
            end
        end
    end

    task automatic alu_op(input logic [1:0] wb, input logic [31:0] alu, input logic [4:0] rd);
        @(posedge clk);
        #1;
        wb_i = wb; rd_i = 1'b0; wr_i = 1'b0; alu_i = alu; data_i = 32'h0; dst_i = rd;
        if (wb != 2'b00) sb.push_back('{wb: wb, alu: alu, md: 32'h0, rd: rd});
        #1;
        chk("alu_no_stall", {70'h0, stall}, 71'h0);
    endtask

    task automatic mem_op(input logic [1:0] wb, input logic ld, input logic st,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input bit alter);
        int          idx;
        int          n;
        logic [31:0] md;
        @(posedge clk);
        #1;
        wb_i = wb; rd_i = ld; wr_i = st; alu_i = addr; data_i = data; dst_i = rd;
        idx = int'((addr >> 2) & (DEPTH - 1));
        md  = 32'h0;
        if (ld && !st) md = model[idx];
        if (st) model[idx] = data;
        if (wb != 2'b00) sb.push_back('{wb: wb, alu: addr, md: md, rd: rd});
        #1;
        n = 0;
        while (stall === 1'b1 && n < 20) begin
            n++;
            @(posedge clk);
            #1;
            if (alter && n == 1) begin
                alu_i  = 32'h20;
                data_i = 32'hBAD0_BAD0;
            end
            #1;
            chk("bubble_in_stall", {69'h0, wb_o}, 71'h0);
        end
        exp_stalls += MEM_LAT;
        chk("stall_cycles", 71'(n), 71'(MEM_LAT));
        chk("stall_cnt", {39'h0, stall_cnt}, 71'(exp_stalls));
    endtask

    initial begin
        checks = 0; errors = 0; exp_stalls = 0;
        rst = 1'b1;
        wb_i = 2'b00; rd_i = 1'b0; wr_i = 1'b0; alu_i = 32'h0; data_i = 32'h0; dst_i = 5'h0;
        #12;
        chk("reset_outputs", {wb_o, alu_o, md_o, dst_o}, 71'h0);
        chk("reset_stall", {38'h0, stall, stall_cnt}, 71'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU pass-through, back to back.
        alu_op(2'b01, 32'h1234, 5'd5);
        alu_op(2'b11, 32'hCAFE_0001, 5'd31);
        alu_op(2'b10, 32'h0000_00FF, 5'd1);

        // Store then load of the same word; store returns no WB entry.
        mem_op(2'b00, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0);
        mem_op(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd9, 1'b0);
        alu_op(2'b01, 32'h5555_AAAA, 5'd12);

        // Address/data change mid-access are ignored.
        mem_op(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd3, 1'b1);
        // Misaligned address uses the same word.
        mem_op(2'b01, 1'b1, 1'b0, 32'h13, 32'h0, 5'd4, 1'b0);

        // Reset in the first BUSY cycle aborts a store.
        mem_op(2'b00, 1'b0, 1'b1, 32'h40, 32'h1111_1111, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        wb_i = 2'b00; rd_i = 1'b0; wr_i = 1'b1; alu_i = 32'h40; data_i = 32'h2222_2222;
        dst_i = 5'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        wr_i = 1'b0; alu_i = 32'h0; data_i = 32'h0;
        #1;
        chk("rst_mid_outputs", {wb_o, alu_o, md_o, dst_o}, 71'h0);
        chk("rst_mid_stall", {38'h0, stall, stall_cnt}, 71'h0);
        exp_stalls = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_op(2'b01, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7, 1'b0);

        // Address wrap plus dual request behaves as a store with zero load data.
        mem_op(2'b10, 1'b1, 1'b1, 32'h400, 32'h55, 5'd2, 1'b0);
        mem_op(2'b11, 1'b1, 1'b0, 32'h0, 32'h0, 5'd8, 1'b0);
        mem_op(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd10, 1'b0);
        alu_op(2'b01, 32'h0BAD_F00D, 5'd6);

        @(posedge clk);
        #1;
        wb_i = 2'b00; rd_i = 1'b0; wr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 71'(sb.size()), 71'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
